control_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/program_counter.sv | 40 ++++
 rtl/control_sequencer.sv | 123 ++++++++++++
 tb/tb_control_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the shared-bus datapath: control-word bit indices,
// opcodes and the sequencer state encoding.
package cpu_pkg;

   localparam int unsigned CS_EPC    = 0;
   localparam int unsigned CS_LMAR   = 1;
   localparam int unsigned CS_EMEM   = 2;
   localparam int unsigned CS_ED0    = 3;
   localparam int unsigned CS_ED1    = 4;
   localparam int unsigned CS_EALU   = 5;
   localparam int unsigned CS_LIR    = 6;
   localparam int unsigned CS_ALUSUB = 7;
   localparam int unsigned CS_WMEM   = 8;
   localparam int unsigned CS_CD0    = 9;
   localparam int unsigned CS_CD1    = 10;
   localparam int unsigned CS_CPC    = 11;
   localparam int unsigned CS_IPC    = 12;
   localparam int unsigned CS_LOUT   = 13;
   localparam int unsigned CS_LFLAG  = 14;
   localparam int unsigned CS_HLT    = 15;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD0 = 4'h1;
   localparam logic [3:0] OP_LD1 = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_ST0 = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH_A,
      ST_FETCH_B,
      ST_DECODE,
      ST_OPA_A,
      ST_OPA_B,
      ST_EXEC,
      ST_HALT
   } state_e;

   function automatic logic [15:0] cw_bit(input int unsigned idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/program_counter.sv
// 8-bit program counter: load from the bus has priority over increment, and
// the counter drives the shared bus only while drive_i is high.
module program_counter #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic       inc_i,
   input  logic       drive_i,
   inout  wire  [7:0] bus_io,
   output logic [7:0] pc_o
);

   logic [7:0] pc_q;
   logic [7:0] pc_d;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path infers a latch.
      pc_d = pc_q;
      if (load_i) begin
         pc_d = bus_io;
      end else if (inc_i) begin
         pc_d = pc_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus_io = drive_i ? pc_q : 8'hzz;
   assign pc_o   = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: fetches instructions over the shared bus, holds the
// opcode and zero flag, and issues the 16-bit control word for the datapath.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Run,
   input  logic        Zero,
   inout  wire  [7:0]  DataBus,
   output logic [15:0] ControlSignals,
   output logic        Halted,
   output logic [7:0]  Pc
);

   state_e      state_q;
   state_e      state_d;
   logic [3:0]  ir_q;      // only the opcode nibble of IR is ever decoded
   logic        zflag_q;
   logic        halted_q;
   logic [15:0] cw;

   // The control word is decoded combinationally so it can react to Run in
   // FETCH_A and be forced to zero while reset is high within the same cycle.
   always_comb begin
      state_d = state_q;
      cw      = '0;
      case (state_q)
         ST_FETCH_A: begin
            if (Run) begin
               cw      = cw_bit(CS_EPC) | cw_bit(CS_LMAR);
               state_d = ST_FETCH_B;
            end
         end
         ST_FETCH_B: begin
            cw      = cw_bit(CS_EMEM) | cw_bit(CS_LIR) | cw_bit(CS_IPC);
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_q)
               OP_LD0, OP_LD1, OP_ST0, OP_JMP, OP_JZ: state_d = ST_OPA_A;
               OP_ADD, OP_SUB, OP_OUT:                state_d = ST_EXEC;
               OP_HLT:                                state_d = ST_HALT;
               OP_NOP:                                state_d = ST_FETCH_A;
               default:                               state_d = ST_FETCH_A;
            endcase
         end
         ST_OPA_A: begin
            cw      = cw_bit(CS_EPC) | cw_bit(CS_LMAR);
            state_d = ST_OPA_B;
         end
         ST_OPA_B: begin
            if (ir_q == OP_JMP || (ir_q == OP_JZ && zflag_q)) begin
               cw      = cw_bit(CS_EMEM) | cw_bit(CS_CPC);
               state_d = ST_FETCH_A;
            end else if (ir_q == OP_JZ) begin
               cw      = cw_bit(CS_IPC);
               state_d = ST_FETCH_A;
            end else begin
               cw      = cw_bit(CS_EMEM) | cw_bit(CS_LMAR) | cw_bit(CS_IPC);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (ir_q)
               OP_LD0:  cw = cw_bit(CS_EMEM) | cw_bit(CS_CD0);
               OP_LD1:  cw = cw_bit(CS_EMEM) | cw_bit(CS_CD1);
               OP_ST0:  cw = cw_bit(CS_ED0) | cw_bit(CS_WMEM);
               OP_ADD:  cw = cw_bit(CS_EALU) | cw_bit(CS_CD0) | cw_bit(CS_LFLAG);
               OP_SUB:  cw = cw_bit(CS_EALU) | cw_bit(CS_CD0) | cw_bit(CS_LFLAG)
                             | cw_bit(CS_ALUSUB);
               OP_OUT:  cw = cw_bit(CS_ED0) | cw_bit(CS_LOUT);
               default: cw = '0;
            endcase
            state_d = ST_FETCH_A;
         end
         ST_HALT: begin
            cw      = cw_bit(CS_HLT);
            state_d = ST_HALT;
         end
         default: state_d = ST_FETCH_A;
      endcase
      if (reset) begin
         cw = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_FETCH_A;
         ir_q     <= '0;
         zflag_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == ST_HALT);
         if (cw[CS_LIR]) begin
            ir_q <= DataBus[7:4];
         end
         if (cw[CS_LFLAG]) begin
            zflag_q <= Zero;
         end
      end
   end

   program_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .load_i  (cw[CS_CPC]),
      .inc_i   (cw[CS_IPC]),
      .drive_i (cw[CS_EPC]),
      .bus_io  (DataBus),
      .pc_o    (Pc)
   );

   assign ControlSignals = cw;
   assign Halted         = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: bench-side datapath (memory, MAR, D0, D1, ALU,
// output register) plus an instruction-level model feeding a per-cycle scoreboard.
module tb_control_sequencer;
   import cpu_pkg::*;

   localparam logic [7:0]  RESET_PC   = 8'h00;
   localparam logic [15:0] OWNER_MASK = 16'h003D;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic        run     = 1'b0;
   logic        preload = 1'b0;
   wire         zero;
   wire  [7:0]  data_bus;
   logic [15:0] cs;
   logic        halted;
   logic [7:0]  pc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   control_sequencer #(
      .RESET_PC (RESET_PC)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .Run            (run),
      .Zero           (zero),
      .DataBus        (data_bus),
      .ControlSignals (cs),
      .Halted         (halted),
      .Pc             (pc)
   );

   // Undriven bus reads as all ones, so a stray PC drive shows up.
   pullup (data_bus);

   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic [7:0] mar, d0, d1, outr;

   wire [7:0] alu_res   = cs[CS_ALUSUB] ? d0 - d1 : d0 + d1;
   wire       bench_drv = |(cs & 16'h003C);
   wire [7:0] bench_val = cs[CS_EMEM] ? mem[mar] :
                          cs[CS_ED0]  ? d0 :
                          cs[CS_ED1]  ? d1 : alu_res;
   assign data_bus = bench_drv ? bench_val : 8'hzz;
   assign zero     = (alu_res == 8'h00);

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
         mar  <= 8'h00;
         d0   <= 8'h00;
         d1   <= 8'h00;
         outr <= 8'h00;
      end else begin
         if (cs[CS_LMAR]) mar <= data_bus;
         if (cs[CS_WMEM]) mem[mar] <= data_bus;
         if (cs[CS_CD0])  d0 <= data_bus;
         if (cs[CS_CD1])  d1 <= data_bus;
         if (cs[CS_LOUT]) outr <= data_bus;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] cw;
      logic [7:0]  pc;
      logic        chk_pc;
   } exp_t;

   exp_t exp_q[$];
   bit   sched[$];
   exp_t mon_e;

   // Instruction-level model state.
   logic [7:0] m_mem [256];
   logic [7:0] m_pc, m_d0, m_d1, m_out;
   bit         m_z, m_halt;

   function automatic bit rr();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_cycle(input logic [15:0] w, input bit chk, input bit rn);
      exp_t e;
      e.cw     = w;
      e.pc     = m_pc;
      e.chk_pc = chk;
      exp_q.push_back(e);
      sched.push_back(rn);
   endtask

   // One architectural instruction: expected control words per cycle and effects.
   task automatic model_step();
      logic [3:0] op;
      logic [7:0] opnd;
      op = m_mem[m_pc][7:4];
      push_cycle(16'h0003, 1'b1, 1'b1);
      push_cycle(16'h1044, 1'b0, rr());
      m_pc = m_pc + 8'd1;
      push_cycle(16'h0000, 1'b0, rr());
      case (op)
         4'h1, 4'h2, 4'h5: begin
            push_cycle(16'h0003, 1'b0, rr());
            push_cycle(16'h1006, 1'b0, rr());
            opnd = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            if (op == 4'h1) begin
               push_cycle(16'h0204, 1'b0, rr());
               m_d0 = m_mem[opnd];
            end else if (op == 4'h2) begin
               push_cycle(16'h0404, 1'b0, rr());
               m_d1 = m_mem[opnd];
            end else begin
               push_cycle(16'h0108, 1'b0, rr());
               m_mem[opnd] = m_d0;
            end
         end
         4'h6: begin
            push_cycle(16'h0003, 1'b0, rr());
            push_cycle(16'h0804, 1'b0, rr());
            m_pc = m_mem[m_pc];
         end
         4'h7: begin
            push_cycle(16'h0003, 1'b0, rr());
            if (m_z) begin
               push_cycle(16'h0804, 1'b0, rr());
               m_pc = m_mem[m_pc];
            end else begin
               push_cycle(16'h1000, 1'b0, rr());
               m_pc = m_pc + 8'd1;
            end
         end
         4'h3: begin
            push_cycle(16'h4220, 1'b0, rr());
            m_d0 = m_d0 + m_d1;
            m_z  = (m_d0 == 8'h00);
         end
         4'h4: begin
            push_cycle(16'h42A0, 1'b0, rr());
            m_d0 = m_d0 - m_d1;
            m_z  = (m_d0 == 8'h00);
         end
         4'h8: begin
            push_cycle(16'h2008, 1'b0, rr());
            m_out = m_d0;
         end
         4'hF: m_halt = 1'b1;
         default: ;
      endcase
   endtask

   task automatic preload_image();
      for (int i = 0; i < 256; i++) img[i] = m_mem[i];
      exp_q.delete();
      sched.delete();
      reset   = 1'b1;
      run     = 1'b0;
      preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      @(posedge clk); #1;
      m_pc   = RESET_PC;
      m_d0   = 8'h00;
      m_d1   = 8'h00;
      m_out  = 8'h00;
      m_z    = 1'b0;
      m_halt = 1'b0;
   endtask

   task automatic run_program(input string tag, input int n_instr, input int lead_idle,
                              input bit rand_idle);
      int bad;
      preload_image();
      repeat (lead_idle) push_cycle(16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < n_instr && !m_halt; i++) begin
         if (rand_idle) repeat ($urandom_range(0, 2)) push_cycle(16'h0000, 1'b1, 1'b0);
         model_step();
      end
      reset = 1'b0;
      run   = sched.pop_front();
      while (sched.size() > 0) begin
         @(posedge clk); #1;
         run = sched.pop_front();
      end
      @(posedge clk); #1;
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_pc"}, pc, m_pc);
      check({tag, "_d0"}, d0, m_d0);
      check({tag, "_d1"}, d1, m_d1);
      check({tag, "_out"}, outr, m_out);
      check({tag, "_halted"}, halted, m_halt);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
      check({tag, "_mem_diffs"}, bad, 0);
   endtask

   task automatic clear_image();
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
   endtask

   // Scoreboard monitor plus the per-cycle bus-ownership check.
   always @(negedge clk) begin
      if (!reset) begin
         check("bus_owner", ($countones(cs & OWNER_MASK) <= 1), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cw", cs, mon_e.cw);
            if (mon_e.chk_pc) check("fetch_pc", pc, mon_e.pc);
            if (mon_e.cw == 16'h0000) check("bus_idle", data_bus, 8'hFF);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      @(posedge clk); #1;
      check("reset_cw", cs, 16'h0000);
      check("reset_pc", pc, RESET_PC);
      check("reset_halted", halted, 1'b0);

      clear_image();
      m_mem[8'h00] = 8'h10; m_mem[8'h01] = 8'h05; m_mem[8'h05] = 8'h2A;
      run_program("ld0", 1, 0, 1'b0);
      run_program("run_low", 1, 6, 1'b0);

      clear_image();
      m_mem[8'h00] = 8'h10; m_mem[8'h01] = 8'h10;
      m_mem[8'h02] = 8'h20; m_mem[8'h03] = 8'h11;
      m_mem[8'h04] = 8'h40;
      m_mem[8'h05] = 8'h70; m_mem[8'h06] = 8'h40;
      m_mem[8'h10] = 8'h03; m_mem[8'h11] = 8'h03;
      run_program("sub_jz", 4, 0, 1'b0);
      check("sub_jz_target", pc, 8'h40);

      clear_image();
      m_mem[8'h00] = 8'h70; m_mem[8'h01] = 8'h40;
      run_program("jz_not_taken", 1, 0, 1'b0);
      check("jz_not_taken_pc", pc, 8'h02);

      clear_image();
      m_mem[8'h00] = 8'h60; m_mem[8'h01] = 8'hFF;
      m_mem[8'hFF] = 8'h10; m_mem[8'h60] = 8'h77;
      run_program("wrap", 2, 0, 1'b0);

      clear_image();
      m_mem[8'h00] = 8'hF0;
      run_program("hlt", 1, 0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         run = rr();
         @(posedge clk); #1;
         check("halt_flag", halted, 1'b1);
         check("halt_cw", cs, 16'h8000);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      run   = 1'b0;
      #1;
      check("halt_reset_pc", pc, RESET_PC);
      check("halt_reset_flag", halted, 1'b0);
      check("halt_reset_cw", cs, 16'h0000);

      clear_image();
      m_mem[8'h00] = 8'h50; m_mem[8'h01] = 8'h30; m_mem[8'h30] = 8'hC3;
      preload_image();
      reset = 1'b0;
      run   = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(posedge clk); #1;
         if (cs == 16'h0108) seen = 1'b1;
      end
      check("st0_exec_reached", seen, 1'b1);
      reset = 1'b1;
      #1;
      check("st0_reset_cw", cs, 16'h0000);
      @(posedge clk); #1;
      check("st0_no_write", mem[8'h30], 8'hC3);
      check("st0_reset_pc", pc, RESET_PC);
      reset = 1'b0;
      run   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("st0_no_wmem", cs[CS_WMEM], 1'b0);
      end

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
         run_program($sformatf("rand%0d", r), 25, 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
